// File: rtl/chip7458_sweep_ctrl.sv
// Exhaustive functional sweep controller for a 7458 dual AND-OR-INVERT-free gate pair.
// Drives all 1024 input vectors, compares both outputs and records mismatch statistics.
module chip7458_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [9:0]  drv,
  input  logic        p1y,
  input  logic        p2y,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [10:0] err_count,
  output logic [9:0]  first_fail_vec,
  output logic        first_fail_valid
);

  typedef enum logic [2:0] {StIdle, StApply, StSettle, StCheck, StDone} state_e;

  localparam logic [3:0]  SettleLast = 4'(SETTLE_CYCLES - 1);
  localparam logic [10:0] ErrMax     = 11'd1024;

  state_e      state_q, state_d;
  logic [9:0]  vec_q, vec_d;
  logic [3:0]  settle_q, settle_d;
  logic [10:0] err_q, err_d;
  logic [9:0]  ffv_q, ffv_d;
  logic        ffvalid_q, ffvalid_d;
  logic        pass_q, pass_d;

  logic exp1, exp2, mismatch;

  assign exp1     = (&vec_q[2:0]) | (&vec_q[5:3]);
  assign exp2     = (&vec_q[7:6]) | (&vec_q[9:8]);
  assign mismatch = (p1y != exp1) | (p2y != exp2);

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d     = '0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
          vec_d     = '0;
          state_d   = StApply;
        end
      end
      StApply: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = StIdle;
        end else if (SETTLE_CYCLES == 0) begin
          state_d = StCheck;
        end else begin
          settle_d = '0;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = StIdle;
        end else if (settle_q == SettleLast) begin
          state_d = StCheck;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StCheck: begin
        if (abort) begin
          // Vector in flight is discarded; statistics freeze at their current values.
          pass_d  = 1'b0;
          state_d = StIdle;
        end else begin
          if (mismatch) begin
            if (err_q != ErrMax) err_d = err_q + 11'd1;
            if (!ffvalid_q) begin
              ffv_d     = vec_q;
              ffvalid_d = 1'b1;
            end
          end
          if (vec_q == 10'd1023) begin
            pass_d  = (err_d == 11'd0);
            state_d = StDone;
          end else begin
            vec_d   = vec_q + 10'd1;
            state_d = StApply;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      settle_q  <= '0;
      err_q     <= '0;
      ffv_q     <= '0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
    end
  end

  assign busy             = (state_q == StApply) || (state_q == StSettle) || (state_q == StCheck);
  assign done             = (state_q == StDone);
  assign drv              = busy ? vec_q : 10'd0;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_chip7458_sweep_ctrl.sv
// Scoreboard bench for chip7458_sweep_ctrl: a behavioural 7458 with injectable faults,
// expected sweep results queued at start and checked by a monitor on each done pulse.
module tb_chip7458_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, start1;
  logic [9:0]  drv, drv1;
  logic        p1y, p2y, p1y1, p2y1;
  logic        busy, done, pass, ffvalid;
  logic        busy1, done1, pass1, ffvalid1;
  logic [10:0] errc, errc1;
  logic [9:0]  ffv, ffv1;

  int fault = 0;
  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          done_cyc;
    logic        pass;
    logic [10:0] errc;
    logic [9:0]  ffv;
    logic        ffvalid;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic m1(input logic [9:0] d);
    return (d[0] & d[1] & d[2]) | (d[3] & d[4] & d[5]);
  endfunction
  function automatic logic m2(input logic [9:0] d);
    return (d[6] & d[7]) | (d[8] & d[9]);
  endfunction

  // fault 1: p2y stuck at 0; fault 2: p1y stuck at 1
  assign p1y  = (fault == 2) ? 1'b1 : m1(drv);
  assign p2y  = (fault == 1) ? 1'b0 : m2(drv);
  assign p1y1 = m1(drv1);
  assign p2y1 = m2(drv1);

  chip7458_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .drv(drv),
    .p1y(p1y), .p2y(p2y), .busy(busy), .done(done), .pass(pass),
    .err_count(errc), .first_fail_vec(ffv), .first_fail_valid(ffvalid)
  );

  chip7458_sweep_ctrl #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0), .drv(drv1),
    .p1y(p1y1), .p2y(p2y1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(errc1), .first_fail_vec(ffv1), .first_fail_valid(ffvalid1)
  );

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("pass", int'(pass), int'(e.pass));
          check("err_count", int'(errc), int'(e.errc));
          check("first_fail_valid", int'(ffvalid), int'(e.ffvalid));
          if (e.ffvalid) check("first_fail_vec", int'(ffv), int'(e.ffv));
          check("busy_in_done", int'(busy), 0);
          check("drv_in_done", int'(drv), 0);
        end
      end
    end
  end

  task automatic accept_start(input bit with_abort, output int acc);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    acc   = cyc;
  endtask

  task automatic run_sweep(input int f, input int ec, input int fv, input bit fvalid,
                           input bit poke, input bit with_abort);
    int   acc;
    int   g;
    exp_t e;
    fault = f;
    accept_start(with_abort, acc);
    e.done_cyc = acc + 4096;
    e.pass     = (ec == 0);
    e.errc     = 11'(ec);
    e.ffv      = 10'(fv);
    e.ffvalid  = fvalid;
    sb.push_back(e);
    if (poke) begin
      repeat (500) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      check("sweep_timeout", 0, 1);
      sb.delete();
    end
    repeat (5) @(negedge clk);
    check("hold_err_count", int'(errc), ec);
    check("hold_pass", int'(pass), int'(ec == 0));
    check("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int bad;
    int g;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_drv", int'(drv), 0);
    check("rst_pass", int'(pass), 0);
    check("rst_err_count", int'(errc), 0);
    check("rst_ffv", int'(ffv), 0);
    check("rst_ffvalid", int'(ffvalid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_sweep(0, 0, 0, 1'b0, 1'b1, 1'b0);        // good part, start poked mid-sweep
    run_sweep(1, 448, 'h0C0, 1'b1, 1'b0, 1'b0);  // p2y stuck 0
    run_sweep(2, 784, 'h000, 1'b1, 1'b0, 1'b1);  // p1y stuck 1, abort with start ignored

    // Abort seen at edge acc+100: vectors 0..23 checked, 7/15/23 match -> 21 errors.
    fault = 2;
    accept_start(1'b0, acc);
    repeat (100) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_drv", int'(drv), 0);
    check("abort_done", int'(done), 0);
    check("abort_pass", int'(pass), 0);
    check("abort_err_count", int'(errc), 21);
    check("abort_ffvalid", int'(ffvalid), 1);
    check("abort_ffv", int'(ffv), 0);
    repeat (4200) @(negedge clk);
    check("abort_hold_err", int'(errc), 21);

    // Reset mid-sweep: outputs clear asynchronously, no done afterwards.
    accept_start(1'b0, acc);
    repeat (300) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_drv", int'(drv), 0);
    check("mrst_done", int'(done), 0);
    check("mrst_pass", int'(pass), 0);
    check("mrst_err_count", int'(errc), 0);
    check("mrst_ffv", int'(ffv), 0);
    check("mrst_ffvalid", int'(ffvalid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4200) @(negedge clk);
    check("mrst_idle_busy", int'(busy), 0);
    run_sweep(0, 0, 0, 1'b0, 1'b0, 1'b0);

    // SETTLE_CYCLES=0 instance: each vector held exactly 2 cycles, done after 2048.
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    acc    = cyc;
    bad    = 0;
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      if (drv1 != 10'((cyc - acc) / 2) || busy1 !== 1'b1) bad++;
    end
    check("s0_drv_hold_bad", bad, 0);
    g = 0;
    while (done1 !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("s0_done_cycle", cyc - acc, 2048);
    check("s0_pass", int'(pass1), 1);
    check("s0_err_count", int'(errc1), 0);
    check("s0_drv_done", int'(drv1), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/chip7458_sweep_ctrl.md
CHIP7458_SWEEP_CTRL -- requirements
Module: chip7458_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning idle cycles between applying a vector and sampling DUT outputs (legal range 0..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  level-sampled request to begin an exhaustive sweep.
REQ-005 SHALL have port abort  input  1  terminates a sweep in progress.
REQ-006 SHALL have port drv  output  10  stimulus to the 7458 DUT: bits 0..5 = p1a..p1f, bits 6..9 = p2a..p2d.
REQ-007 SHALL have port p1y  input  1  DUT section-1 output.
REQ-008 SHALL have port p2y  input  1  DUT section-2 output.
REQ-009 SHALL have port busy  output  1  sweep in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse on sweep completion.
REQ-011 SHALL have port pass  output  1  last completed sweep had zero mismatches.
REQ-012 SHALL have port err_count  output  11  number of mismatching vectors in current/last sweep.
REQ-013 SHALL have port first_fail_vec  output  10  drv value of the first mismatching vector.
REQ-014 SHALL have port first_fail_valid  output  1  first_fail_vec holds a captured value.

Function
REQ-015 SHALL implement states IDLE, APPLY, SETTLE, CHECK, DONE.
REQ-016 In IDLE, start=1 at a rising edge SHALL clear err_count, first_fail_valid, pass, set vector counter to 0, and go to APPLY.
REQ-017 APPLY SHALL last exactly 1 cycle with drv = vector counter, then go to SETTLE, or to CHECK when SETTLE_CYCLES=0.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles with drv held, then go to CHECK.
REQ-019 CHECK SHALL last 1 cycle, sample p1y/p2y, and compare them to exp1 = (p1a&p1b&p1c)|(p1d&p1e&p1f), exp2 = (p2a&p2b)|(p2c&p2d) computed from the vector counter.
REQ-020 A mismatch on either output SHALL increment err_count by exactly 1 per vector; err_count cannot overflow (max 1024).
REQ-021 The first mismatch of a sweep SHALL load first_fail_vec and set first_fail_valid; later mismatches SHALL not change them.
REQ-022 From CHECK, vector 1023 SHALL go to DONE; otherwise counter SHALL increment and go to APPLY.
REQ-023 DONE SHALL last 1 cycle with done=1 and pass=(err_count==0 including final vector), then return to IDLE.
REQ-024 Sweep duration from start-accept edge to done=1 SHALL be exactly 1024*(SETTLE_CYCLES+2) cycles.
REQ-025 busy SHALL be 1 in APPLY, SETTLE, CHECK and 0 in IDLE and DONE.
REQ-026 drv SHALL be 0 in IDLE and DONE.
REQ-027 start while busy SHALL be ignored; start held high through DONE SHALL begin a new sweep on the first IDLE cycle.
REQ-028 abort=1 in APPLY, SETTLE or CHECK SHALL go to IDLE next edge, without done pulse, pass=0, err_count/first_fail_* holding their values at abort; abort in IDLE/DONE SHALL be ignored.
REQ-029 abort and start both high in IDLE SHALL start the sweep (abort ignored).
REQ-030 pass, err_count, first_fail_* SHALL hold between sweeps until the next accepted start.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, counter 0, drv=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, first_fail_valid=0, regardless of state.
REQ-032 Reset asserted mid-sweep SHALL discard the sweep; no done pulse SHALL follow reset release.

Verification
REQ-033 Correct 7458 model, SETTLE_CYCLES=2, start pulse -> done exactly 4096 cycles later, pass=1, err_count=0, first_fail_valid=0.
REQ-034 p2y stuck at 0 -> err_count=448, first_fail_vec=0x0C0, pass=0.
REQ-035 p1y stuck at 1 -> err_count=784, first_fail_vec=0x000, pass=0.
REQ-036 SETTLE_CYCLES=0, correct model -> done 2048 cycles after start; each drv value held 2 cycles.
REQ-037 abort at cycle 100 after start -> busy=0 next cycle, drv=0, no done, pass=0; start during sweep ignored (done time unchanged).
REQ-038 rst_n pulsed low mid-sweep -> all outputs zero asynchronously, no done after release; subsequent start runs full sweep normally.
